// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared types and constants for the multi-channel encoder
//               counter (channel FSM states, counting modes, filter length).
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    // Per-channel control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_Z = 2'd1,
        ACTIVE = 2'd2
    } enc_state_t;

    // Counting modes
    localparam int MODE_CUM = 0;  // cumulative: Z only snapshots
    localparam int MODE_REV = 1;  // per revolution: Z snapshots then clears

    // Stability window of the optional glitch filter, in clocks
    localparam int FILT_LEN = 4;

endpackage
`default_nettype wire

// File: rtl/enc_cnt_ch.sv
`default_nettype none
// ============================================================================
// Module      : enc_cnt_ch
// Description : One encoder channel: A/Z synchroniser, optional stability
//               filter (ENC_GLITCH_FILTER_EN), rising-edge detect, arm/index
//               FSM, counter with sticky overflow, and Z snapshot register.
// Ports       : clk, rst (async, active-high), i_arm (level), i_a/i_z (raw
//               async pins), o_a/o_z (edge pulses), o_cnt, o_snap,
//               o_snap_vld, o_overflow, o_ready.
// Macros      : ENC_GLITCH_FILTER_EN - enables the per-signal stability filter
// Revision    : 1.0 - initial release
// ============================================================================
module enc_cnt_ch
    import enc_pkg::*;
#(
    parameter int CW       = 64,
    parameter int MODE     = MODE_CUM,
    parameter int SYNC_STG = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_arm,
    input  logic          i_a,
    input  logic          i_z,
    output logic          o_a,
    output logic          o_z,
    output logic [CW-1:0] o_cnt,
    output logic [CW-1:0] o_snap,
    output logic          o_snap_vld,
    output logic          o_overflow,
    output logic          o_ready
);

    // Bit 0 carries A, bit 1 carries Z through the whole input path.
    logic [1:0]                w_raw;
    logic [SYNC_STG-1:0][1:0]  r_sync;
    logic [1:0]                w_sync;
    logic [1:0]                w_clean;
    logic [1:0]                r_prev;
    logic [1:0]                r_pls;
    logic                      w_a_edge;
    logic                      w_z_edge;

    enc_state_t                r_state;
    enc_state_t                w_state_nxt;

    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             r_snap;
    logic                      r_snap_vld;
    logic                      r_ovf;
    logic                      r_ready;
    logic [CW-1:0]             w_cnt_inc;
    logic                      w_cnt_max;

    assign w_raw  = {i_z, i_a};
    assign w_sync = r_sync[SYNC_STG-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], w_raw};
        end
    end

`ifdef ENC_GLITCH_FILTER_EN
    localparam int c_filt_w = $clog2(FILT_LEN + 1);

    // A new level is accepted only after it has differed from the accepted
    // level for FILT_LEN consecutive clocks; any bounce restarts the run.
    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic [c_filt_w-1:0] r_run;
        logic                r_lvl;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_run <= '0;
                r_lvl <= 1'b0;
            end else if (w_sync[g] == r_lvl) begin
                r_run <= '0;
            end else if (r_run == c_filt_w'(FILT_LEN - 1)) begin
                r_lvl <= w_sync[g];
                r_run <= '0;
            end else begin
                r_run <= r_run + c_filt_w'(1);
            end
        end

        assign w_clean[g] = r_lvl;
    end
`else
    assign w_clean = w_sync;
`endif

    // Registered edge pulses; these drive both the outputs and the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
            r_pls  <= '0;
        end else begin
            r_prev <= w_clean;
            r_pls  <= w_clean & ~r_prev;
        end
    end

    assign w_a_edge = r_pls[0];
    assign w_z_edge = r_pls[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!i_arm) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = WAIT_Z;
                WAIT_Z:  if (w_z_edge) w_state_nxt = ACTIVE;
                ACTIVE:  w_state_nxt = ACTIVE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_cnt_max = &r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_snap     <= '0;
            r_snap_vld <= 1'b0;
            r_ovf      <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_snap_vld <= 1'b0;
            // Tracks the next state so O_READY equals (state == ACTIVE).
            r_ready    <= (w_state_nxt == ACTIVE);
            if (r_state == IDLE && i_arm) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (r_state == ACTIVE) begin
                if (w_z_edge) begin
                    // A coincident A edge is included in the snapshot.
                    r_snap     <= w_a_edge ? w_cnt_inc : r_cnt;
                    r_snap_vld <= 1'b1;
                end
                if (w_z_edge && MODE == MODE_REV) begin
                    r_cnt <= '0;
                end else if (w_a_edge) begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_max) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_a        = w_a_edge;
    assign o_z        = w_z_edge;
    assign o_cnt      = r_cnt;
    assign o_snap     = r_snap;
    assign o_snap_vld = r_snap_vld;
    assign o_overflow = r_ovf;
    assign o_ready    = r_ready;

endmodule
`default_nettype wire

// File: rtl/enc_cnt_multi.sv
`default_nettype none
// ============================================================================
// Module      : enc_cnt_multi
// Description : NCH independent encoder counters sharing clock, reset and
//               arm. Per-channel vectors are packed with channel k at
//               [k*CW +: CW].
// Ports       : CLK, I_RST (async, active-high), I_ARM, I_A/I_Z [NCH] raw
//               pins, O_A/O_Z [NCH] edge pulses, O_CNT/O_SNAP [NCH*CW],
//               O_SNAP_VLD, O_OVERFLOW, O_READY [NCH].
// Macros      : ENC_GLITCH_FILTER_EN - per-channel glitch filter on A and Z
// Revision    : 1.0 - initial release
// ============================================================================
module enc_cnt_multi
    import enc_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int CW       = 64,
    parameter int MODE     = MODE_CUM,
    parameter int SYNC_STG = 2
) (
    input  logic              CLK,
    input  logic              I_RST,
    input  logic              I_ARM,
    input  logic [NCH-1:0]    I_A,
    input  logic [NCH-1:0]    I_Z,
    output logic [NCH-1:0]    O_A,
    output logic [NCH-1:0]    O_Z,
    output logic [NCH*CW-1:0] O_CNT,
    output logic [NCH*CW-1:0] O_SNAP,
    output logic [NCH-1:0]    O_SNAP_VLD,
    output logic [NCH-1:0]    O_OVERFLOW,
    output logic [NCH-1:0]    O_READY
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        enc_cnt_ch #(
            .CW       (CW),
            .MODE     (MODE),
            .SYNC_STG (SYNC_STG)
        ) u_ch (
            .clk        (CLK),
            .rst        (I_RST),
            .i_arm      (I_ARM),
            .i_a        (I_A[k]),
            .i_z        (I_Z[k]),
            .o_a        (O_A[k]),
            .o_z        (O_Z[k]),
            .o_cnt      (O_CNT[k*CW +: CW]),
            .o_snap     (O_SNAP[k*CW +: CW]),
            .o_snap_vld (O_SNAP_VLD[k]),
            .o_overflow (O_OVERFLOW[k]),
            .o_ready    (O_READY[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_enc_cnt_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_enc_cnt_multi
// Description : Self-checking bench for enc_cnt_multi. Two instances (MODE 0
//               and MODE 1, CW=8, NCH=2) share one stimulus stream; an
//               event-level reference model predicts counts, snapshots,
//               overflow, readiness and pulse totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_cnt_multi;

    localparam int NCH = 2;
    localparam int CW  = 8;
    localparam int MOD = 256;

    logic              CLK = 1'b0;
    logic              I_RST;
    logic              I_ARM;
    logic [NCH-1:0]    I_A;
    logic [NCH-1:0]    I_Z;
    logic [NCH-1:0]    o_a    [2];
    logic [NCH-1:0]    o_z    [2];
    logic [NCH-1:0]    o_vld  [2];
    logic [NCH-1:0]    o_ovf  [2];
    logic [NCH-1:0]    o_rdy  [2];
    logic [NCH*CW-1:0] o_cnt  [2];
    logic [NCH*CW-1:0] o_snap [2];

    for (genvar m = 0; m < 2; m++) begin : g_dut
        enc_cnt_multi #(.NCH(NCH), .CW(CW), .MODE(m), .SYNC_STG(2)) u_dut (
            .CLK        (CLK),
            .I_RST      (I_RST),
            .I_ARM      (I_ARM),
            .I_A        (I_A),
            .I_Z        (I_Z),
            .O_A        (o_a[m]),
            .O_Z        (o_z[m]),
            .O_CNT      (o_cnt[m]),
            .O_SNAP     (o_snap[m]),
            .O_SNAP_VLD (o_vld[m]),
            .O_OVERFLOW (o_ovf[m]),
            .O_READY    (o_rdy[m])
        );
    end

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: [mode][channel]
    int m_cnt  [2][NCH];
    int m_snap [2][NCH];
    int m_ovf  [2][NCH];
    int m_vld  [2][NCH];
    int m_apul [NCH];
    int m_zpul [NCH];
    bit m_wait [NCH];
    bit m_act  [NCH];

    // Observed pulse totals
    int s_apul [2][NCH];
    int s_zpul [2][NCH];
    int s_vld  [2][NCH];

    initial begin
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < NCH; k++) begin
                s_apul[m][k] = 0; s_zpul[m][k] = 0; s_vld[m][k] = 0;
            end
    end

    always @(negedge CLK) begin
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < NCH; k++) begin
                if (o_a[m][k] === 1'b1)   s_apul[m][k]++;
                if (o_z[m][k] === 1'b1)   s_zpul[m][k]++;
                if (o_vld[m][k] === 1'b1) s_vld[m][k]++;
            end
    end

    function automatic int dcnt(input int m, input int k);
        return int'(o_cnt[m][k*CW +: CW]);
    endfunction

    function automatic int dsnap(input int m, input int k);
        return int'(o_snap[m][k*CW +: CW]);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            m_wait[k] = 1'b0;
            m_act[k]  = 1'b0;
            for (int m = 0; m < 2; m++) begin
                m_cnt[m][k] = 0; m_snap[m][k] = 0; m_ovf[m][k] = 0;
            end
        end
    endtask

    task automatic do_arm(input bit v);
        if (v && I_ARM == 1'b0) begin
            for (int k = 0; k < NCH; k++) begin
                m_wait[k] = 1'b1;
                m_act[k]  = 1'b0;
                for (int m = 0; m < 2; m++) begin
                    m_cnt[m][k] = 0; m_ovf[m][k] = 0;
                end
            end
        end
        if (!v) begin
            for (int k = 0; k < NCH; k++) begin
                m_wait[k] = 1'b0;
                m_act[k]  = 1'b0;
            end
        end
        I_ARM = v;
        repeat (3) @(negedge CLK);
    endtask

    // One clean pulse on the selected pins (rising edges coincide), then
    // enough quiet time for it to propagate fully.
    task automatic do_pulse(input logic [NCH-1:0] am, input logic [NCH-1:0] zm);
        I_A = am;
        I_Z = zm;
        repeat (6) @(negedge CLK);
        I_A = '0;
        I_Z = '0;
        repeat (6) @(negedge CLK);
        for (int k = 0; k < NCH; k++) begin
            if (am[k]) m_apul[k]++;
            if (zm[k]) m_zpul[k]++;
            if (m_act[k]) begin
                for (int m = 0; m < 2; m++) begin
                    if (zm[k]) begin
                        m_snap[m][k] = (m_cnt[m][k] + int'(am[k])) % MOD;
                        m_vld[m][k]++;
                    end
                    if (zm[k] && m == 1) begin
                        m_cnt[m][k] = 0;
                    end else if (am[k]) begin
                        m_cnt[m][k] = (m_cnt[m][k] + 1) % MOD;
                        if (m_cnt[m][k] == 0) m_ovf[m][k] = 1;
                    end
                end
            end else if (m_wait[k] && zm[k]) begin
                m_wait[k] = 1'b0;
                m_act[k]  = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [2*NCH*CW+5*NCH-1:0] v;
        I_RST = 1'b1; I_ARM = 1'b0; I_A = '0; I_Z = '0;
        model_clear();
        for (int k = 0; k < NCH; k++) begin
            m_apul[k] = 0; m_zpul[k] = 0; m_vld[0][k] = 0; m_vld[1][k] = 0;
        end
        repeat (3) @(negedge CLK);
        I_RST = 1'b0;
        repeat (3) @(negedge CLK);
        for (int m = 0; m < 2; m++) begin
            v = {o_cnt[m], o_snap[m], o_a[m], o_z[m], o_vld[m], o_ovf[m], o_rdy[m]};
            n_checks++;
            if (v !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs mode%0d: got %h expected 0", m, v);
            end
        end
    endtask

    task automatic test_cumulative();
        do_arm(1'b1);
        repeat (3) do_pulse(2'b01, 2'b00);
        n_checks++;
        if (o_rdy[0][0] !== 1'b0) begin
            n_errors++;
            $display("FAIL cum_ready_before_z: got %b expected 0", o_rdy[0][0]);
        end
        do_pulse(2'b00, 2'b01);
        repeat (5) do_pulse(2'b01, 2'b00);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (o_rdy[m][0] !== 1'b1) begin
                n_errors++;
                $display("FAIL cum_ready mode%0d: got %b expected 1", m, o_rdy[m][0]);
            end
            n_checks++;
            if (dcnt(m, 0) !== m_cnt[m][0] || m_cnt[m][0] != 5) begin
                n_errors++;
                $display("FAIL cum_cnt mode%0d: got %0d expected 5", m, dcnt(m, 0));
            end
            n_checks++;
            if (dsnap(m, 0) !== 0) begin
                n_errors++;
                $display("FAIL cum_snap mode%0d: got %0d expected 0", m, dsnap(m, 0));
            end
        end
    endtask

    task automatic test_per_rev();
        int v0;
        do_arm(1'b0);
        do_arm(1'b1);
        do_pulse(2'b00, 2'b01);
        v0 = s_vld[1][0];
        for (int r = 0; r < 4; r++) begin
            repeat (3) do_pulse(2'b01, 2'b00);
            do_pulse(2'b00, 2'b01);
            n_checks++;
            if (dsnap(1, 0) !== m_snap[1][0] || dcnt(1, 0) !== m_cnt[1][0]) begin
                n_errors++;
                $display("FAIL rev_snap_cnt rev%0d: got snap=%0d cnt=%0d expected snap=%0d cnt=%0d",
                         r, dsnap(1, 0), dcnt(1, 0), m_snap[1][0], m_cnt[1][0]);
            end
        end
        n_checks++;
        if (s_vld[1][0] - v0 !== 4) begin
            n_errors++;
            $display("FAIL rev_vld_pulses: got %0d expected 4", s_vld[1][0] - v0);
        end
        n_checks++;
        if (dsnap(0, 0) !== m_snap[0][0] || dcnt(0, 0) !== m_cnt[0][0]) begin
            n_errors++;
            $display("FAIL cum_rev_snap_cnt: got snap=%0d cnt=%0d expected snap=%0d cnt=%0d",
                     dsnap(0, 0), dcnt(0, 0), m_snap[0][0], m_cnt[0][0]);
        end
    endtask

    task automatic test_overflow();
        do_arm(1'b0);
        do_arm(1'b1);
        do_pulse(2'b00, 2'b01);
        repeat (255) do_pulse(2'b01, 2'b00);
        n_checks++;
        if (o_ovf[0][0] !== 1'b0 || dcnt(0, 0) !== 255) begin
            n_errors++;
            $display("FAIL ovf_at_max: got ovf=%b cnt=%0d expected ovf=0 cnt=255", o_ovf[0][0], dcnt(0, 0));
        end
        do_pulse(2'b01, 2'b00);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (o_ovf[m][0] !== 1'(m_ovf[m][0]) || dcnt(m, 0) !== m_cnt[m][0]) begin
                n_errors++;
                $display("FAIL ovf_wrap mode%0d: got ovf=%b cnt=%0d expected ovf=%0d cnt=%0d",
                         m, o_ovf[m][0], dcnt(m, 0), m_ovf[m][0], m_cnt[m][0]);
            end
        end
        repeat (3) do_pulse(2'b01, 2'b00);
        n_checks++;
        if (o_ovf[0][0] !== 1'b1 || dcnt(0, 0) !== m_cnt[0][0]) begin
            n_errors++;
            $display("FAIL ovf_sticky: got ovf=%b cnt=%0d expected ovf=1 cnt=%0d", o_ovf[0][0], dcnt(0, 0), m_cnt[0][0]);
        end
        do_arm(1'b0);
        do_arm(1'b1);
        n_checks++;
        if (o_ovf[0][0] !== 1'b0 || dcnt(0, 0) !== 0) begin
            n_errors++;
            $display("FAIL ovf_rearm_clear: got ovf=%b cnt=%0d expected ovf=0 cnt=0", o_ovf[0][0], dcnt(0, 0));
        end
    endtask

    task automatic test_simultaneous();
        do_arm(1'b0);
        do_arm(1'b1);
        do_pulse(2'b01, 2'b01);
        n_checks++;
        if (dcnt(0, 0) !== 0 || o_rdy[0][0] !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_waitz: got cnt=%0d ready=%b expected cnt=0 ready=1", dcnt(0, 0), o_rdy[0][0]);
        end
        repeat (7) do_pulse(2'b01, 2'b00);
        do_pulse(2'b01, 2'b01);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (dsnap(m, 0) !== m_snap[m][0] || dcnt(m, 0) !== m_cnt[m][0]) begin
                n_errors++;
                $display("FAIL simul_active mode%0d: got snap=%0d cnt=%0d expected snap=%0d cnt=%0d",
                         m, dsnap(m, 0), dcnt(m, 0), m_snap[m][0], m_cnt[m][0]);
            end
        end
    endtask

    task automatic test_multi_channel();
        logic [NCH-1:0] am;
        logic [NCH-1:0] zm;
        for (int it = 0; it < 5; it++) begin
            do_arm(1'b0);
            do_arm(1'b1);
            for (int p = 0; p < 100; p++) begin
                am = NCH'($urandom);
                zm = '0;
                for (int k = 0; k < NCH; k++)
                    if ($urandom_range(0, 9) == 0) zm[k] = 1'b1;
                do_pulse(am, zm);
            end
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < NCH; k++) begin
                    n_checks++;
                    if (dcnt(m, k) !== m_cnt[m][k] || dsnap(m, k) !== m_snap[m][k] ||
                        o_ovf[m][k] !== 1'(m_ovf[m][k]) || o_rdy[m][k] !== m_act[k]) begin
                        n_errors++;
                        $display("FAIL multi_state it%0d mode%0d ch%0d: got cnt=%0d snap=%0d ovf=%b rdy=%b expected cnt=%0d snap=%0d ovf=%0d rdy=%0d",
                                 it, m, k, dcnt(m, k), dsnap(m, k), o_ovf[m][k], o_rdy[m][k],
                                 m_cnt[m][k], m_snap[m][k], m_ovf[m][k], m_act[k]);
                    end
                    n_checks++;
                    if (s_apul[m][k] !== m_apul[k] || s_zpul[m][k] !== m_zpul[k] || s_vld[m][k] !== m_vld[m][k]) begin
                        n_errors++;
                        $display("FAIL multi_pulses it%0d mode%0d ch%0d: got a=%0d z=%0d vld=%0d expected a=%0d z=%0d vld=%0d",
                                 it, m, k, s_apul[m][k], s_zpul[m][k], s_vld[m][k],
                                 m_apul[k], m_zpul[k], m_vld[m][k]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2*NCH*CW+5*NCH-1:0] v;
        do_arm(1'b0);
        do_arm(1'b1);
        do_pulse(2'b00, 2'b01);
        repeat (42) do_pulse(2'b01, 2'b00);
        n_checks++;
        if (dcnt(0, 0) !== 42) begin
            n_errors++;
            $display("FAIL rst_mid_precount: got %0d expected 42", dcnt(0, 0));
        end
        @(negedge CLK);
        #2;
        I_RST = 1'b1;
        I_ARM = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            v = {o_cnt[m], o_snap[m], o_a[m], o_z[m], o_vld[m], o_ovf[m], o_rdy[m]};
            n_checks++;
            if (v !== '0) begin
                n_errors++;
                $display("FAIL rst_mid_async mode%0d: got %h expected 0", m, v);
            end
        end
        @(negedge CLK);
        I_RST = 1'b0;
        model_clear();
        do_arm(1'b1);
        repeat (3) do_pulse(2'b01, 2'b00);
        n_checks++;
        if (dcnt(0, 0) !== 0 || o_rdy[0][0] !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_waitz: got cnt=%0d rdy=%b expected cnt=0 rdy=0", dcnt(0, 0), o_rdy[0][0]);
        end
        do_pulse(2'b00, 2'b01);
        do_pulse(2'b01, 2'b00);
        n_checks++;
        if (dcnt(0, 0) !== m_cnt[0][0] || o_rdy[0][0] !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_resume: got cnt=%0d rdy=%b expected cnt=%0d rdy=1", dcnt(0, 0), o_rdy[0][0], m_cnt[0][0]);
        end
    endtask

`ifdef ENC_GLITCH_FILTER_EN
    task automatic test_glitch();
        int a0;
        a0 = s_apul[0][0];
        I_A = 2'b01;
        repeat (2) @(negedge CLK);
        I_A = '0;
        repeat (12) @(negedge CLK);
        n_checks++;
        if (dcnt(0, 0) !== m_cnt[0][0] || s_apul[0][0] !== a0) begin
            n_errors++;
            $display("FAIL glitch_reject: got cnt=%0d a_pulses=%0d expected cnt=%0d a_pulses=%0d",
                     dcnt(0, 0), s_apul[0][0], m_cnt[0][0], a0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cumulative();
        test_per_rev();
        test_overflow();
        test_simultaneous();
        test_multi_channel();
        test_reset_mid();
`ifdef ENC_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
